// File: rtl/umai_tx_striper.sv
`default_nettype none
// ============================================================================
// Module   : umai_tx_striper
// Brief    : Splits UMAI beats into 72-bit flits striped round-robin over AIB
//            channels, one flit per cycle through a single-beat holding reg.
// Revision : 1.0 - initial release
// ============================================================================
module umai_tx_striper #(
  parameter  int NumChannels = 8,
  parameter  int DataWidth   = 512,
  localparam int NumChunks   = DataWidth / 64
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [2:0]               c_first_chn_id,
  input  logic [2:0]               c_last_chn_id,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [DataWidth-1:0]     i_data,
  input  logic                     i_last,
  output logic [NumChannels-1:0]   o_tx_valid,
  input  logic [NumChannels-1:0]   i_tx_ready,
  output logic [NumChannels*72-1:0] o_tx_data,
  output logic [15:0]              o_beat_cnt
);

  localparam logic [3:0] LAST_CHUNK = 4'(NumChunks - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [DataWidth-1:0] r_data;
  logic                 r_last;
  logic [3:0]           r_k;
  logic [2:0]           r_ptr;
  logic [15:0]          r_beat_cnt;

  logic                 w_cur_ready;
  logic                 w_last_chunk;
  logic                 w_hs;
  logic                 w_accept;
  logic [2:0]           w_ptr_adv;
  logic [2:0]           w_ptr_nxt;
  logic [63:0]          w_chunk;
  logic [71:0]          w_flit;

  // An inverted window (first > last) collapses to the single channel 'first'.
  function automatic logic f_in_range(input logic [2:0] p, input logic [2:0] f,
                                      input logic [2:0] l);
    return (f > l) ? (p == f) : ((p >= f) && (p <= l));
  endfunction

  always_comb begin
    w_cur_ready = 1'b0;
    for (int ch = 0; ch < NumChannels; ch++) begin
      if (r_ptr == 3'(ch)) w_cur_ready = i_tx_ready[ch];
    end
  end

  assign w_last_chunk = (r_k == LAST_CHUNK);
  assign w_hs         = (r_state == SEND) && w_cur_ready;
  assign o_ready      = (r_state == IDLE) || (w_last_chunk && w_hs);
  assign w_accept     = i_valid && o_ready;
  assign o_beat_cnt   = r_beat_cnt;

  always_comb begin
    w_ptr_adv = r_ptr;
    if (w_hs) begin
      if ((c_first_chn_id > c_last_chn_id) || (r_ptr == c_last_chn_id)) begin
        w_ptr_adv = c_first_chn_id;
      end else begin
        w_ptr_adv = r_ptr + 3'd1;
      end
    end
    // Range check uses the post-advance pointer so back-to-back beats stay in order.
    w_ptr_nxt = w_ptr_adv;
    if (w_accept && !f_in_range(w_ptr_adv, c_first_chn_id, c_last_chn_id)) begin
      w_ptr_nxt = c_first_chn_id;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = SEND;
      SEND:    if (w_hs && w_last_chunk && !w_accept) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_data     <= '0;
      r_last     <= 1'b0;
      r_k        <= 4'd0;
      r_ptr      <= 3'd0;
      r_beat_cnt <= 16'd0;
    end else begin
      r_ptr <= w_ptr_nxt;
      if (w_accept) begin
        r_data     <= i_data;
        r_last     <= i_last;
        r_k        <= 4'd0;
        r_beat_cnt <= r_beat_cnt + 16'd1;
      end else if (w_hs) begin
        r_k <= r_k + 4'd1;
      end
    end
  end

  always_comb begin
    w_chunk = '0;
    for (int c = 0; c < NumChunks; c++) begin
      if (r_k == 4'(c)) w_chunk = r_data[c*64 +: 64];
    end
  end

  assign w_flit = {2'b01, r_last && w_last_chunk, w_last_chunk, r_k, w_chunk};

  always_comb begin
    o_tx_valid = '0;
    o_tx_data  = '0;
    for (int ch = 0; ch < NumChannels; ch++) begin
      if ((r_state == SEND) && (r_ptr == 3'(ch))) begin
        o_tx_valid[ch]          = 1'b1;
        o_tx_data[ch*72 +: 72]  = w_flit;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_umai_tx_striper.sv
`default_nettype none
// ============================================================================
// Module   : tb_umai_tx_striper
// Brief    : Self-checking bench: flit-queue model plus directed literal checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_umai_tx_striper;

  logic         clk;
  logic         rst_n;
  logic [2:0]   c_first;
  logic [2:0]   c_last;
  logic         i_valid;
  logic         o_ready;
  logic [511:0] i_data;
  logic         i_last;
  logic [7:0]   o_tx_valid;
  logic [7:0]   i_tx_ready;
  logic [575:0] o_tx_data;
  logic [15:0]  o_beat_cnt;

  logic         w_valid;
  logic         w_ready;
  logic [63:0]  w_data;
  logic [1:0]   w_txv;
  logic [1:0]   w_txr;
  logic [143:0] w_txd;
  logic [15:0]  w_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  umai_tx_striper u_dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .c_first_chn_id (c_first),
    .c_last_chn_id  (c_last),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .i_data         (i_data),
    .i_last         (i_last),
    .o_tx_valid     (o_tx_valid),
    .i_tx_ready     (i_tx_ready),
    .o_tx_data      (o_tx_data),
    .o_beat_cnt     (o_beat_cnt)
  );

  // Narrow instance: one chunk per beat, so the 16-bit counter wraps quickly.
  umai_tx_striper #(.NumChannels(2), .DataWidth(64)) u_dut_w (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .c_first_chn_id (3'd0),
    .c_last_chn_id  (3'd1),
    .i_valid        (w_valid),
    .o_ready        (w_ready),
    .i_data         (w_data),
    .i_last         (1'b1),
    .o_tx_valid     (w_txv),
    .i_tx_ready     (w_txr),
    .o_tx_data      (w_txd),
    .o_beat_cnt     (w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model: pending flits of the held beat ----------
  typedef struct {
    logic [2:0]  ch;
    logic [71:0] flit;
  } flit_t;

  flit_t      q[$];
  logic [2:0] m_ptr = 3'd0;
  logic [15:0] m_cnt = 16'd0;
  logic       m_acc = 1'b0;

  function automatic logic in_window(input logic [2:0] p);
    if (c_first > c_last) return p == c_first;
    return (p >= c_first) && (p <= c_last);
  endfunction

  function automatic logic [2:0] next_ch(input logic [2:0] p);
    if (c_first > c_last || p == c_last) return c_first;
    return p + 3'd1;
  endfunction

  always @(negedge clk) begin : compare
    logic [7:0]   exp_valid;
    logic [575:0] exp_data;
    logic         exp_ready;
    flit_t        e;
    if (!rst_n) begin
      q.delete();
      m_ptr = 3'd0;
      m_cnt = 16'd0;
    end
    exp_valid = '0;
    exp_data  = '0;
    if (q.size() > 0) begin
      exp_valid[q[0].ch]          = 1'b1;
      exp_data[q[0].ch*72 +: 72]  = q[0].flit;
    end
    exp_ready = (q.size() == 0) || (q.size() == 1 && i_tx_ready[q[0].ch]);
    check("model_tx_valid", {568'd0, o_tx_valid}, {568'd0, exp_valid});
    check("model_tx_data", o_tx_data, exp_data);
    check("model_ready", {575'd0, o_ready}, {575'd0, exp_ready});
    check("model_beat_cnt", {560'd0, o_beat_cnt}, {560'd0, m_cnt});
    m_acc = 1'b0;
    if (rst_n) begin
      if (q.size() > 0 && i_tx_ready[q[0].ch]) void'(q.pop_front());
      if (i_valid && exp_ready) begin
        m_acc = 1'b1;
        m_cnt = m_cnt + 16'd1;
        for (int c = 0; c < 8; c++) begin
          if (c == 0 && !in_window(m_ptr)) m_ptr = c_first;
          e.ch   = m_ptr;
          e.flit = {2'b01, i_last && (c == 7), (c == 7), 4'(c), i_data[c*64 +: 64]};
          q.push_back(e);
          m_ptr = next_ch(m_ptr);
        end
      end
    end
  end

  // ---------------- stimulus helpers ------------------------------------------
  function automatic logic [511:0] mk(input logic [31:0] seed);
    logic [511:0] d;
    for (int c = 0; c < 8; c++) d[c*64 +: 64] = {seed, 28'h0, 4'(c)};
    return d;
  endfunction

  task automatic send_beat(input logic [31:0] seed, input logic last, output int t_acc);
    i_valid = 1'b1;
    i_data  = mk(seed);
    i_last  = last;
    t_acc   = -1;
    for (int t = 0; t < 100; t++) begin
      @(posedge clk);
      if (m_acc) begin
        #1;
        t_acc   = cyc;
        i_valid = 1'b0;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL accept_timeout: got no acceptance expected acceptance within 100 cycles");
    #1 i_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int t = 0; t < 100; t++) begin
      if (q.size() == 0) return;
      step();
    end
    n_vec++;
    n_err++;
    $display("FAIL drain_timeout: got %0d pending flits expected 0", q.size());
  endtask

  // ---------------- directed sequence -----------------------------------------
  initial begin : stim
    int ta, tb;
    rst_n      = 1'b0;
    c_first    = 3'd0;
    c_last     = 3'd7;
    i_valid    = 1'b0;
    i_data     = '0;
    i_last     = 1'b0;
    i_tx_ready = 8'hFF;
    w_valid    = 1'b0;
    w_data     = 64'h1;
    w_txr      = 2'b11;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("reset_ready", {575'd0, o_ready}, {575'd0, 1'b1});
    check("reset_valid", {568'd0, o_tx_valid}, 576'd0);
    check("reset_cnt", {560'd0, o_beat_cnt}, 576'd0);

    // Single beat over channels 0..7.
    send_beat(32'hDEADBEEF, 1'b1, ta);
    check("t1_first_valid", {568'd0, o_tx_valid}, {568'd0, 8'h01});
    check("t1_chunk0", {512'd0, o_tx_data[63:0]}, {512'd0, 64'hDEADBEEF_00000000});
    repeat (7) step();
    check("t1_last_valid", {568'd0, o_tx_valid}, {568'd0, 8'h80});
    check("t1_last_hdr", {568'd0, o_tx_data[7*72+64 +: 8]}, {568'd0, 8'h77});
    check("t1_chunk7", {512'd0, o_tx_data[7*72 +: 64]}, {512'd0, 64'hDEADBEEF_00000007});
    step();
    check("t1_idle_valid", {568'd0, o_tx_valid}, 576'd0);
    check("t1_cnt", {560'd0, o_beat_cnt}, {560'd0, 16'd1});
    drain();

    // Window 2..4, two back-to-back beats.
    c_first = 3'd2;
    c_last  = 3'd4;
    send_beat(32'h0000A0A0, 1'b0, ta);
    check("t2_first_ch", {568'd0, o_tx_valid}, {568'd0, 8'h04});
    send_beat(32'h0000B0B0, 1'b1, tb);
    check("t2_no_bubble", 576'(tb - ta), 576'd8);
    check("t2_b_first_ch", {568'd0, o_tx_valid}, {568'd0, 8'h10});
    check("t2_b_flit0", {504'd0, o_tx_data[4*72 +: 72]}, {504'd0, 8'h40, 64'h0000B0B0_00000000});
    drain();

    // Inverted window: everything on channel 5.
    c_first = 3'd5;
    c_last  = 3'd1;
    send_beat(32'h55550005, 1'b1, ta);
    check("t4_first_ch", {568'd0, o_tx_valid}, {568'd0, 8'h20});
    repeat (7) step();
    check("t4_last_ch", {568'd0, o_tx_valid}, {568'd0, 8'h20});
    check("t4_last_hdr", {568'd0, o_tx_data[5*72+64 +: 8]}, {568'd0, 8'h77});
    drain();

    // Reset in the middle of a beat.
    c_first = 3'd0;
    c_last  = 3'd7;
    send_beat(32'hC0C00003, 1'b1, ta);
    repeat (4) step();
    check("t5_pre_reset_ch", {568'd0, o_tx_valid}, {568'd0, 8'h02});
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {568'd0, o_tx_valid}, 576'd0);
    check("t5_rst_data", o_tx_data, 576'd0);
    check("t5_rst_cnt", {560'd0, o_beat_cnt}, 576'd0);
    check("t5_rst_ready", {575'd0, o_ready}, {575'd0, 1'b1});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("t5_rel_ready", {575'd0, o_ready}, {575'd0, 1'b1});
    check("t5_rel_cnt", {560'd0, o_beat_cnt}, 576'd0);
    step();
    check("t5_no_partial", {568'd0, o_tx_valid}, 576'd0);
    send_beat(32'h00000F0F, 1'b0, ta);
    check("t5_ptr_zero", {568'd0, o_tx_valid}, {568'd0, 8'h01});
    drain();

    // Stall on channel 3 during chunk 1.
    c_first = 3'd2;
    c_last  = 3'd7;
    send_beat(32'h33330001, 1'b1, ta);
    check("t3_chunk0_ch", {568'd0, o_tx_valid}, {568'd0, 8'h04});
    i_tx_ready = 8'hF7;
    step();
    for (int i = 0; i < 5; i++) begin
      check("t3_hold_valid", {568'd0, o_tx_valid}, {568'd0, 8'h08});
      check("t3_hold_flit", {504'd0, o_tx_data[3*72 +: 72]}, {504'd0, 8'h41, 64'h33330001_00000001});
      check("t3_hold_ready", {575'd0, o_ready}, 576'd0);
      if (i < 4) step();
    end
    i_tx_ready = 8'hFF;
    step();
    check("t3_resume_ch", {568'd0, o_tx_valid}, {568'd0, 8'h10});
    drain();

    // Beat counter wrap on the narrow instance.
    w_valid = 1'b1;
    for (int n = 1; n <= 65537; n++) begin
      step();
      if (n == 65535) check("wrap_ffff", {560'd0, w_cnt}, {560'd0, 16'hFFFF});
      if (n == 65536) check("wrap_zero", {560'd0, w_cnt}, 576'd0);
    end
    w_valid = 1'b0;
    check("wrap_one", {560'd0, w_cnt}, {560'd0, 16'd1});
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
